sa_tile_sequencer: RTL
======================

// Module: sa_tile_sequencer
// PURPOSE
//   Sequences one HPE x VPE systolic-array tile: clears accumulators, streams K operand beats from the
//   A/B operand buffer, and drives per-lane skew enables (lane i delayed i cycles). It then waits for the
//   array to drain and hands results out one row at a time over a valid/ready handshake.
//   Sits between the host/DMA command interface and the array datapath plus its operand buffer.
// PARAMETERS
//   WIDTH  8   operand width (informational; sequencer carries no data)
//   HPE    8   horizontal PEs = skew lanes, >=1
//   VPE    8   vertical PEs = result rows, >=1
//   KW     16  width of K_LEN
//   AW     10  operand-buffer address width
// PORTS
//   CLK        in   1          clock; all logic on posedge
//   RST        in   1          synchronous, active-high reset
//   START      in   1          command strobe; accepted only in IDLE
//   K_LEN      in   KW         operand beats; sampled on accepted START
//   BASE_ADDR  in   AW         first buffer address; sampled on accepted START
//   ABORT      in   1          cancel current tile
//   BUSY       out  1          high in every state except IDLE
//   RD_EN      out  1          operand-buffer read strobe (buffer read latency = 1)
//   RD_ADDR    out  AW         operand-buffer address
//   LANE_EN    out  HPE        skew-lane data-valid enables
//   ACC_CLR    out  1          accumulator clear pulse
//   ACC_EN     out  1          array MAC enable
//   OUT_VALID  out  1          result row valid
//   OUT_ROW    out  clog2(VPE) row index (width 1 if VPE==1)
//   OUT_READY  in   1          sink accepts row
//   DONE       out  1          one-cycle tile-complete pulse
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters 0. RST overrides ABORT/START; works in any state, mid-tile included.
// - FSM: IDLE -> CLEAR -> FEED -> DRAIN -> OUTPUT -> FIN -> IDLE.
//   IDLE:   START=1 at cycle 0 -> CLEAR at cycle 1. START in any other state is ignored, never queued.
//   CLEAR:  1 cycle; ACC_CLR=1. Next state is FEED, or DRAIN when K_LEN==0.
//   FEED:   exactly K cycles; RD_EN=1, RD_ADDR=BASE+t (t=0..K-1, modulo 2^AW wrap); ACC_EN=1.
//   DRAIN:  fixed HPE+VPE cycles (1 read + HPE-1 skew + VPE-1 propagate + 1 MAC reg); ACC_EN=1.
//   OUTPUT: OUT_VALID=1, OUT_ROW=r starting at 0. r increments on OUT_VALID&OUT_READY.
//           Handshake on r==VPE-1 -> FIN. With OUT_READY low, OUT_VALID and OUT_ROW hold stable.
//   FIN:    DONE=1 for 1 cycle -> IDLE. A START in the cycle after FIN is accepted.
// - LANE_EN[i] = RD_EN delayed 1+i cycles (shift register). Lane i is high for exactly K cycles,
//   first FEED cycle +1+i onward; LANE_EN spans into DRAIN as required.
// - ABORT (any non-IDLE state, RST low): next cycle IDLE. RD_EN, LANE_EN, ACC_*, OUT_VALID all 0.
//   No DONE. ABORT in IDLE has no effect. ABORT has priority over START in the same cycle.
// - ACC_CLR, RD_EN, ACC_EN, OUT_VALID, DONE are registered (Moore) outputs; no combinational IN->OUT paths.
// - K counter is KW bits wide. K_LEN = 2^KW-1 is legal, with no overflow.
// CONFIGURATION
//   SA_SEQ_PERF_CNT_EN defined:
//     adds port PERF_CYC out 32 = cycles from START-accept cycle to DONE cycle.
//     Latched on DONE and held until the next DONE. Internal count saturates at 2^32-1.
//     Reset 0; ABORT leaves PERF_CYC unchanged.
//   SA_SEQ_PERF_CNT_EN undefined: port and counter absent. All other behaviour is identical.
// TESTING (HPE=VPE=4, AW=10 unless noted; cycle 0 = START accept)
// 1 K_LEN=3, BASE=0x010, OUT_READY=1 -> ACC_CLR @1; RD_ADDR 0x010/011/012 @2-4; LANE_EN[0] @3-5;
//   LANE_EN[3] @6-8; ACC_EN @2-12; OUT_ROW 0..3 @13-16; DONE @17; PERF_CYC=17 if enabled.
// 2 As 1, OUT_READY low 5 cycles while OUT_ROW=1 -> OUT_VALID held, OUT_ROW stays 1; DONE @22.
// 3 START pulsed @5 during tile, then K_LEN=0 tile -> second START ignored; next tile: no RD_EN,
//   no LANE_EN; DRAIN @2-9; DONE @14.
// 4 ABORT @3 (FEED) -> @4 BUSY=0, RD_EN=0, LANE_EN=0; DONE never pulses; new START @5 accepted.
// 5 BASE=0x3FF, K_LEN=2 -> RD_ADDR 0x3FF then 0x000. RST @7 (DRAIN) -> @8 all outputs 0, IDLE.
// 6 HPE=VPE=1, K_LEN=1 -> LANE_EN[0] @3, DRAIN @3-4, OUT_ROW=0 @5, DONE @6.

Source files
------------

// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: control sequencer for one HPE x VPE systolic-array tile.
// Clears accumulators, streams K operand beats, drives per-lane skew enables,
// waits out the array drain, then hands result rows out over valid/ready.
// Optional feature macro: SA_SEQ_PERF_CNT_EN adds o_perf_cyc (START-accept to DONE cycle count).
module sa_tile_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned HPE   = 8,
    parameter int unsigned VPE   = 8,
    parameter int unsigned KW    = 16,
    parameter int unsigned AW    = 10
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_start,
    input  logic [KW-1:0]                              i_k_len,
    input  logic [AW-1:0]                              i_base_addr,
    input  logic                                       i_abort,
    output logic                                       o_busy,
    output logic                                       o_rd_en,
    output logic [AW-1:0]                              o_rd_addr,
    output logic [HPE-1:0]                             o_lane_en,
    output logic                                       o_acc_clr,
    output logic                                       o_acc_en,
    output logic                                       o_out_valid,
    output logic [((VPE > 1) ? $clog2(VPE) : 1)-1:0]   o_out_row,
    input  logic                                       i_out_ready,
    output logic                                       o_done
`ifdef SA_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                                o_perf_cyc
`endif
);

    localparam int unsigned RW = (VPE > 1) ? $clog2(VPE) : 1;
    localparam int unsigned DW = $clog2(HPE + VPE);

    // Degenerate array shapes are rejected at elaboration.
    if (WIDTH == 0 || HPE == 0 || VPE == 0) begin : g_param_chk
        $error("sa_tile_sequencer: WIDTH, HPE and VPE must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [KW-1:0]   r_k_len;
    logic [AW-1:0]   r_base;
    logic [KW-1:0]   r_kcnt;
    logic [DW-1:0]   r_dcnt;
    logic            r_busy;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_addr;
    logic [HPE-1:0]  r_lane_en;
    logic            r_acc_clr;
    logic            r_acc_en;
    logic            r_out_valid;
    logic [RW-1:0]   r_out_row;
    logic            r_done;

    logic            w_accept;
    logic            w_abort;
    logic [KW-1:0]   w_kcnt_nxt;
    logic [DW-1:0]   w_dcnt_nxt;
    logic            w_busy_nxt;
    logic            w_rd_en_nxt;
    logic [AW-1:0]   w_rd_addr_nxt;
    logic [HPE-1:0]  w_lane_en_nxt;
    logic            w_acc_clr_nxt;
    logic            w_acc_en_nxt;
    logic            w_out_valid_nxt;
    logic [RW-1:0]   w_out_row_nxt;
    logic            w_done_nxt;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_abort  = (r_state != S_IDLE) && i_abort;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; abort wins over every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (i_start) w_state_nxt = S_CLEAR;
                S_CLEAR:  w_state_nxt = (r_k_len == '0) ? S_DRAIN : S_FEED;
                S_FEED:   if (r_kcnt == r_k_len - KW'(1)) w_state_nxt = S_DRAIN;
                S_DRAIN:  if (r_dcnt == DW'(HPE + VPE - 1)) w_state_nxt = S_OUTPUT;
                S_OUTPUT: if (r_out_valid && i_out_ready && (r_out_row == RW'(VPE - 1)))
                              w_state_nxt = S_FIN;
                S_FIN:    w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output/counter next values, decoded from the upcoming state so every output is a flop.
    always_comb begin
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_acc_clr_nxt   = (w_state_nxt == S_CLEAR);
        w_rd_en_nxt     = (w_state_nxt == S_FEED);
        w_acc_en_nxt    = (w_state_nxt == S_FEED) || (w_state_nxt == S_DRAIN);
        w_out_valid_nxt = (w_state_nxt == S_OUTPUT);
        w_done_nxt      = (w_state_nxt == S_FIN);
        w_rd_addr_nxt   = '0;
        w_out_row_nxt   = '0;
        w_kcnt_nxt      = '0;
        w_dcnt_nxt      = '0;
        w_lane_en_nxt   = w_abort ? '0 : HPE'({r_lane_en, r_rd_en});
        if (w_state_nxt == S_FEED) begin
            w_rd_addr_nxt = (r_state == S_FEED) ? r_rd_addr + AW'(1) : r_base;
            w_kcnt_nxt    = (r_state == S_FEED) ? r_kcnt + KW'(1) : '0;
        end
        if (w_state_nxt == S_DRAIN && r_state == S_DRAIN) begin
            w_dcnt_nxt = r_dcnt + DW'(1);
        end
        if (w_state_nxt == S_OUTPUT) begin
            w_out_row_nxt = (r_state == S_OUTPUT && i_out_ready) ? r_out_row + RW'(1) : r_out_row;
        end
    end

    // Output and counter registers; command fields captured on START accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k_len     <= '0;
            r_base      <= '0;
            r_kcnt      <= '0;
            r_dcnt      <= '0;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_lane_en   <= '0;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_k_len <= i_k_len;
                r_base  <= i_base_addr;
            end
            r_kcnt      <= w_kcnt_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_busy      <= w_busy_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_lane_en   <= w_lane_en_nxt;
            r_acc_clr   <= w_acc_clr_nxt;
            r_acc_en    <= w_acc_en_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_row   <= w_out_row_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_lane_en   = r_lane_en;
    assign o_acc_clr   = r_acc_clr;
    assign o_acc_en    = r_acc_en;
    assign o_out_valid = r_out_valid;
    assign o_out_row   = r_out_row;
    assign o_done      = r_done;

`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0] r_cyc;
    logic [31:0] r_perf;
    logic [31:0] w_cyc_inc;

    assign w_cyc_inc = (r_cyc == '1) ? r_cyc : r_cyc + 32'd1;

    // Tile cycle counter (saturating); result latched alongside the DONE pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc  <= '0;
            r_perf <= '0;
        end else begin
            if (w_accept)              r_cyc <= 32'd1;
            else if (r_state != S_IDLE) r_cyc <= w_cyc_inc;
            if (w_state_nxt == S_FIN)  r_perf <= w_cyc_inc;
        end
    end

    assign o_perf_cyc = r_perf;
`endif

endmodule
